// File: rtl/tank_pkg.sv
// tank_pkg: shared types, state encoding and trig table for the tank
// motion controller.
//   angle_t  - 5-bit heading index, 32 steps of 11.25 degrees
//   trig_t   - signed Q1.6 trig value, +1.0 = 64
//   pos_fx_t - unsigned Q10.6 screen position
//   state_e  - controller FSM states
package tank_pkg;

    typedef logic [4:0]        angle_t;
    typedef logic signed [7:0] trig_t;
    typedef logic [15:0]       pos_fx_t;

    typedef enum logic [1:0] {IDLE, UPDATE, PROBE} state_e;

    localparam int FRAC_W = 6;

    // sin(k * 11.25 deg) * 64, rounded to nearest.
    localparam trig_t SIN_LUT [32] = '{
          8'sd0,   8'sd12,  8'sd24,  8'sd36,  8'sd45,  8'sd53,  8'sd59,  8'sd63,
          8'sd64,  8'sd63,  8'sd59,  8'sd53,  8'sd45,  8'sd36,  8'sd24,  8'sd12,
          8'sd0,  -8'sd12, -8'sd24, -8'sd36, -8'sd45, -8'sd53, -8'sd59, -8'sd63,
         -8'sd64, -8'sd63, -8'sd59, -8'sd53, -8'sd45, -8'sd36, -8'sd24, -8'sd12
    };

    function automatic trig_t sin_of(input angle_t a);
        return SIN_LUT[a];
    endfunction

    // cos leads sin by a quarter turn; the 5-bit add wraps mod 32.
    function automatic trig_t cos_of(input angle_t a);
        angle_t b;
        b = a + 5'd8;
        return SIN_LUT[b];
    endfunction

    // Clamp a signed Q11.6 sum to [lo, hi] on the integer part. A clamped
    // result has its fraction zeroed; an in-range sum keeps its fraction.
    function automatic pos_fx_t clamp_axis(input logic signed [16:0] sum,
                                           input logic [9:0]         lo,
                                           input logic [9:0]         hi);
        logic signed [10:0] ip;
        ip = sum[16:FRAC_W];
        if (ip < $signed({1'b0, lo}))
            return {lo, {FRAC_W{1'b0}}};
        else if (ip > $signed({1'b0, hi}))
            return {hi, {FRAC_W{1'b0}}};
        else
            return sum[15:0];
    endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// frame_tick_sync: brings the asynchronous vertical-sync strobe into the
// clock domain and emits a single-cycle tick on its rising edge.
//   clk_i   - system clock
//   rst_i   - synchronous active-high reset
//   async_i - asynchronous frame strobe
//   tick_o  - registered 1-cycle pulse, 3 clocks after the strobe edge
module frame_tick_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic tick_o
);

    logic meta_q, sync_q, prev_q, tick_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            tick_q <= sync_q & ~prev_q;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/tank_motion.sv
// tank_motion: per-tank motion controller feeding the colour mapper.
// Keycodes rotate the heading or propose a move along it; each proposed
// move is clamped to the playfield and checked against the maze through
// a probe handshake before being committed. One update per video frame.
//   Clk, Reset              - clock, synchronous active-high reset
//   frame_clk               - asynchronous vertical-sync strobe
//   keycode                 - current key, 8'h00 = none
//   probe_ack/probe_blocked - maze checker response
//   probe_req/probe_x/_y    - maze checker request and candidate pixel
//   TankX/TankY             - committed centre position (integer part)
//   angle/sin/cos           - heading index and its Q1.6 sin/cos
//   busy                    - FSM is not in IDLE
module tank_motion
    import tank_pkg::*;
#(
    parameter logic [7:0] KEY_FWD       = 8'h1A,
    parameter logic [7:0] KEY_BACK      = 8'h16,
    parameter logic [7:0] KEY_LEFT      = 8'h04,
    parameter logic [7:0] KEY_RIGHT     = 8'h07,
    parameter int         SPEED         = 2,
    parameter logic [9:0] X_INIT        = 10'd80,
    parameter logic [9:0] Y_INIT        = 10'd80,
    parameter logic [4:0] ANGLE_INIT    = 5'd0,
    parameter logic [9:0] X_MIN         = 10'd8,
    parameter logic [9:0] X_MAX         = 10'd631,
    parameter logic [9:0] Y_MIN         = 10'd8,
    parameter logic [9:0] Y_MAX         = 10'd471,
    parameter int         PROBE_TIMEOUT = 16
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    input  logic       probe_ack,
    input  logic       probe_blocked,
    output logic       probe_req,
    output logic [9:0] probe_x,
    output logic [9:0] probe_y,
    output logic [9:0] TankX,
    output logic [9:0] TankY,
    output logic [4:0] angle,
    output logic [7:0] sin,
    output logic [7:0] cos,
    output logic       busy
);

    localparam int TW = (PROBE_TIMEOUT > 1) ? $clog2(PROBE_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(PROBE_TIMEOUT - 1);
    localparam logic signed [10:0] SPD = 11'(SPEED);

    logic tick;

    frame_tick_sync u_sync (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .async_i (frame_clk),
        .tick_o  (tick)
    );

    state_e          state_q;
    pos_fx_t         pos_x_q, pos_y_q;
    pos_fx_t         cand_x_q, cand_y_q;
    angle_t          angle_q;
    trig_t           sin_q, cos_q;
    logic            probe_req_q;
    logic [9:0]      probe_x_q, probe_y_q;
    logic [TW-1:0]   tmo_q;

    // Candidate position from the current heading.
    logic               is_fwd, is_back, is_move;
    logic signed [10:0] step_x, step_y;
    logic signed [16:0] sum_x, sum_y;
    pos_fx_t            cand_x_d, cand_y_d;

    assign is_fwd  = (keycode == KEY_FWD);
    assign is_back = (keycode == KEY_BACK);
    assign is_move = is_fwd | is_back;

    always_comb begin
        step_x = SPD * $signed({{3{cos_q[7]}}, cos_q});
        step_y = SPD * $signed({{3{sin_q[7]}}, sin_q});
        if (is_back) begin
            sum_x = $signed({1'b0, pos_x_q}) - $signed({{6{step_x[10]}}, step_x});
            sum_y = $signed({1'b0, pos_y_q}) - $signed({{6{step_y[10]}}, step_y});
        end else begin
            sum_x = $signed({1'b0, pos_x_q}) + $signed({{6{step_x[10]}}, step_x});
            sum_y = $signed({1'b0, pos_y_q}) + $signed({{6{step_y[10]}}, step_y});
        end
        cand_x_d = clamp_axis(sum_x, X_MIN, X_MAX);
        cand_y_d = clamp_axis(sum_y, Y_MIN, Y_MAX);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            pos_x_q     <= {X_INIT, {FRAC_W{1'b0}}};
            pos_y_q     <= {Y_INIT, {FRAC_W{1'b0}}};
            cand_x_q    <= '0;
            cand_y_q    <= '0;
            angle_q     <= ANGLE_INIT;
            sin_q       <= sin_of(ANGLE_INIT);
            cos_q       <= cos_of(ANGLE_INIT);
            probe_req_q <= 1'b0;
            probe_x_q   <= '0;
            probe_y_q   <= '0;
            tmo_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (tick) state_q <= UPDATE;
                end
                UPDATE: begin
                    if (keycode == KEY_LEFT) begin
                        angle_q <= angle_q - 5'd1;
                        sin_q   <= sin_of(angle_q - 5'd1);
                        cos_q   <= cos_of(angle_q - 5'd1);
                    end else if (keycode == KEY_RIGHT) begin
                        angle_q <= angle_q + 5'd1;
                        sin_q   <= sin_of(angle_q + 5'd1);
                        cos_q   <= cos_of(angle_q + 5'd1);
                    end
                    if (is_move) begin
                        cand_x_q    <= cand_x_d;
                        cand_y_q    <= cand_y_d;
                        probe_x_q   <= cand_x_d[15:FRAC_W];
                        probe_y_q   <= cand_y_d[15:FRAC_W];
                        probe_req_q <= 1'b1;
                        tmo_q       <= '0;
                        state_q     <= PROBE;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                PROBE: begin
                    if (probe_ack) begin
                        if (!probe_blocked) begin
                            pos_x_q <= cand_x_q;
                            pos_y_q <= cand_y_q;
                        end
                        probe_req_q <= 1'b0;
                        state_q     <= IDLE;
                    end else if (tmo_q == TMO_LAST) begin
                        // Maze checker never answered: drop the move.
                        probe_req_q <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                default: begin
                    probe_req_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign probe_req = probe_req_q;
    assign probe_x   = probe_x_q;
    assign probe_y   = probe_y_q;
    assign TankX     = pos_x_q[15:FRAC_W];
    assign TankY     = pos_y_q[15:FRAC_W];
    assign angle     = angle_q;
    assign sin       = sin_q;
    assign cos       = cos_q;
    assign busy      = (state_q != IDLE);

endmodule
